// File: rtl/e203_ifu_halt_flush_resp_pkg.sv
// Shared types for the IFU halt/flush responder: state encodings and default sizes.
package e203_ifu_halt_flush_resp_pkg;

  localparam int E203_PC_SIZE = 32;
  localparam int E203_IFU_OUTS_MAX = 2;

  typedef enum logic [1:0] {
    E203_IFU_HFR_RUN         = 2'd0,
    E203_IFU_HFR_FLUSH_DRAIN = 2'd1,
    E203_IFU_HFR_HALT_DRAIN  = 2'd2,
    E203_IFU_HFR_HALTED      = 2'd3
  } hfr_state_e;

endpackage

// File: rtl/e203_ifu_outs_cnt.sv
// Outstanding-fetch counter: saturating up/down, flags a response arriving with nothing outstanding.
module e203_ifu_outs_cnt #(
  parameter int OUTS_MAX = 2,
  parameter int CNT_W    = $clog2(OUTS_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  logic [CNT_W-1:0] cnt_reg;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (cnt_reg >= CNT_W'(OUTS_MAX));
  assign at_zero = (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (dec && !inc && !at_zero) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;
  assign err = dec & at_zero & ~rst;

endmodule

// File: rtl/e203_ifu_halt_flush_resp.sv
// IFU responder for flush/halt requests: gates fetch issue, drains outstanding fetches,
// then acknowledges and (for flush) emits the redirect PC.
module e203_ifu_halt_flush_resp
  import e203_ifu_halt_flush_resp_pkg::*;
#(
  parameter int   PC_SIZE  = E203_PC_SIZE,
  parameter int   OUTS_MAX = E203_IFU_OUTS_MAX,
  localparam int  CNT_W    = $clog2(OUTS_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic               pipe_flush_ack,
  input  logic               ifu_halt_req,
  output logic               ifu_halt_ack,
  input  logic               fetch_req_valid,
  input  logic               fetch_req_ready,
  output logic               fetch_issue_allow,
  input  logic               fetch_rsp_valid,
  output logic               fetch_rsp_discard,
  output logic               redirect_vld,
  output logic [PC_SIZE-1:0] redirect_pc,
  output logic [CNT_W-1:0]   outs_cnt,
  output logic               rsp_err
);

  hfr_state_e       state_reg, state_next;
  logic             discard_reg, discard_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_err;
  logic             cnt_zero;
  logic             allow;
  logic             issue_hs;
  logic             flush_done;
  logic [PC_SIZE-1:0] flush_sum;

  e203_ifu_outs_cnt #(
    .OUTS_MAX (OUTS_MAX),
    .CNT_W    (CNT_W)
  ) u_outs_cnt (
    .clk (clk),
    .rst (rst),
    .inc (issue_hs),
    .dec (fetch_rsp_valid),
    .cnt (cnt),
    .err (cnt_err)
  );

  assign cnt_zero = (cnt == '0);

  // A response in the same cycle frees a slot, so a full counter can still accept an issue.
  assign allow = (state_reg == E203_IFU_HFR_RUN) & ~pipe_flush_req & ~ifu_halt_req &
                 ((cnt < CNT_W'(OUTS_MAX)) | fetch_rsp_valid);
  assign issue_hs = fetch_req_valid & fetch_req_ready & allow & ~rst;

  assign flush_done = (state_reg == E203_IFU_HFR_FLUSH_DRAIN) & cnt_zero;
  assign flush_sum  = pipe_flush_add_op1 + pipe_flush_add_op2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= E203_IFU_HFR_RUN;
      discard_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    case (state_reg)
      E203_IFU_HFR_RUN: begin
        if (pipe_flush_req) begin
          state_next   = E203_IFU_HFR_FLUSH_DRAIN;
          discard_next = ~cnt_zero;
        end else if (ifu_halt_req) begin
          state_next = E203_IFU_HFR_HALT_DRAIN;
        end
      end
      E203_IFU_HFR_FLUSH_DRAIN: begin
        if (cnt_zero) begin
          discard_next = 1'b0;
          state_next   = ifu_halt_req ? E203_IFU_HFR_HALT_DRAIN : E203_IFU_HFR_RUN;
        end
      end
      E203_IFU_HFR_HALT_DRAIN: begin
        if (pipe_flush_req) begin
          state_next   = E203_IFU_HFR_FLUSH_DRAIN;
          discard_next = ~cnt_zero;
        end else if (!ifu_halt_req) begin
          state_next = E203_IFU_HFR_RUN;
        end else if (cnt_zero) begin
          state_next = E203_IFU_HFR_HALTED;
        end
      end
      E203_IFU_HFR_HALTED: begin
        if (pipe_flush_req) begin
          state_next = E203_IFU_HFR_FLUSH_DRAIN;
        end else if (!ifu_halt_req) begin
          state_next = E203_IFU_HFR_RUN;
        end
      end
      default: begin
        state_next   = E203_IFU_HFR_RUN;
        discard_next = 1'b0;
      end
    endcase
  end

  // Reset is synchronous, so every output is masked during the reset cycle itself.
  assign pipe_flush_ack    = flush_done & ~rst;
  assign redirect_vld      = flush_done & ~rst;
  assign redirect_pc       = (flush_done & ~rst) ? {flush_sum[PC_SIZE-1:1], 1'b0} : '0;
  assign ifu_halt_ack      = (state_reg == E203_IFU_HFR_HALTED) & ~rst;
  assign fetch_issue_allow = allow & ~rst;
  assign fetch_rsp_discard = fetch_rsp_valid & discard_reg & ~rst;
  assign outs_cnt          = rst ? '0 : cnt;
  assign rsp_err           = cnt_err;

endmodule
